// File: rtl/mem_port_arb.sv
// Two-to-one round-robin arbiter sharing one single-beat memory port between
// instruction fetch (I) and load/store (D), with an order FIFO steering in-order responses.
module mem_port_arb #(
  parameter int C_BUS_SZ        = 32,
  parameter int C_ORDER_DEPTH_X = 2
) (
  input  logic                  clk_i,
  input  logic                  resetb_i,
  input  logic                  clk_en_i,
  output logic                  i_reqready_o,
  input  logic                  i_reqvalid_i,
  input  logic [1:0]            i_reqhpl_i,
  input  logic [C_BUS_SZ-1:0]   i_reqaddr_i,
  input  logic                  i_rspready_i,
  output logic                  i_rspvalid_o,
  output logic                  i_rsprerr_o,
  output logic [C_BUS_SZ-1:0]   i_rspdata_o,
  output logic                  d_reqready_o,
  input  logic                  d_reqvalid_i,
  input  logic [1:0]            d_reqhpl_i,
  input  logic [C_BUS_SZ-1:0]   d_reqaddr_i,
  input  logic                  d_reqwr_i,
  input  logic [C_BUS_SZ/8-1:0] d_reqbe_i,
  input  logic [C_BUS_SZ-1:0]   d_reqwdata_i,
  input  logic                  d_rspready_i,
  output logic                  d_rspvalid_o,
  output logic                  d_rsprerr_o,
  output logic [C_BUS_SZ-1:0]   d_rspdata_o,
  input  logic                  m_reqready_i,
  output logic                  m_reqvalid_o,
  output logic [1:0]            m_reqhpl_o,
  output logic [C_BUS_SZ-1:0]   m_reqaddr_o,
  output logic                  m_reqwr_o,
  output logic [C_BUS_SZ/8-1:0] m_reqbe_o,
  output logic [C_BUS_SZ-1:0]   m_reqwdata_o,
  output logic                  m_rspready_o,
  input  logic                  m_rspvalid_i,
  input  logic                  m_rsprerr_i,
  input  logic [C_BUS_SZ-1:0]   m_rspdata_i,
  output logic                  spurious_rsp_o
);

  localparam int DEPTH = 2 ** C_ORDER_DEPTH_X;

  // Handshakes: a transfer happens in a cycle where valid and ready are both high.
  // A valid request must be held, payload stable, until it is accepted; ready
  // may depend combinationally on valid (zero-latency acceptance).

  logic                       last_grant_q;
  logic                       lock_q;
  logic                       lock_src_q;
  logic                       spurious_q;
  logic [DEPTH-1:0]           order_q;
  logic [C_ORDER_DEPTH_X-1:0] wr_ptr_q;
  logic [C_ORDER_DEPTH_X-1:0] rd_ptr_q;
  logic [C_ORDER_DEPTH_X:0]   level_q;

  logic grant_any;
  logic grant_src;
  logic order_full;
  logic order_empty;
  logic head;
  logic sel_valid;
  logic push;
  logic pop;

  // Level never exceeds DEPTH, so its MSB alone marks a full FIFO.
  assign order_full  = level_q[C_ORDER_DEPTH_X];
  assign order_empty = (level_q == '0);
  assign head        = order_q[rd_ptr_q];

  always_comb begin
    grant_any = 1'b0;
    grant_src = 1'b0;
    if (lock_q) begin
      grant_any = 1'b1;
      grant_src = lock_src_q;
    end else if (i_reqvalid_i && !d_reqvalid_i) begin
      grant_any = 1'b1;
      grant_src = 1'b0;
    end else if (d_reqvalid_i && !i_reqvalid_i) begin
      grant_any = 1'b1;
      grant_src = 1'b1;
    end else if (i_reqvalid_i && d_reqvalid_i) begin
      grant_any = 1'b1;
      grant_src = ~last_grant_q;
    end
  end

  assign sel_valid    = grant_src ? d_reqvalid_i : i_reqvalid_i;
  assign m_reqvalid_o = grant_any & sel_valid & ~order_full;
  assign i_reqready_o = grant_any & ~grant_src & m_reqready_i & ~order_full;
  assign d_reqready_o = grant_any & grant_src & m_reqready_i & ~order_full;

  assign m_reqhpl_o   = grant_src ? d_reqhpl_i : i_reqhpl_i;
  assign m_reqaddr_o  = grant_src ? d_reqaddr_i : i_reqaddr_i;
  assign m_reqwr_o    = grant_src & d_reqwr_i;
  assign m_reqbe_o    = grant_src ? d_reqbe_i : '1;
  assign m_reqwdata_o = grant_src ? d_reqwdata_i : '0;

  assign m_rspready_o = ~order_empty & (head ? d_rspready_i : i_rspready_i);
  assign i_rspvalid_o = m_rspvalid_i & ~order_empty & ~head;
  assign d_rspvalid_o = m_rspvalid_i & ~order_empty & head;
  assign i_rsprerr_o  = m_rsprerr_i;
  assign d_rsprerr_o  = m_rsprerr_i;
  assign i_rspdata_o  = m_rspdata_i;
  assign d_rspdata_o  = m_rspdata_i;
  assign spurious_rsp_o = spurious_q;

  assign push = m_reqvalid_o & m_reqready_i;
  assign pop  = m_rspvalid_i & m_rspready_o;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      lock_src_q   <= 1'b0;
      spurious_q   <= 1'b0;
      order_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else if (clk_en_i) begin
      if (push) begin
        order_q[wr_ptr_q] <= grant_src;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // A presented but refused request pins the grant until it is taken.
      if (push) begin
        last_grant_q <= grant_src;
        lock_q       <= 1'b0;
      end else if (m_reqvalid_o) begin
        lock_q     <= 1'b1;
        lock_src_q <= grant_src;
      end
      if (m_rspvalid_i && order_empty) begin
        spurious_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: a vector table applied cycle by cycle plus
// hand-written sequences for reset, payload muxing and clock-enable corners.
module tb_mem_port_arb;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetb;
  logic         clk_en;
  logic         i_reqready, i_reqvalid, i_rspready, i_rspvalid, i_rsprerr;
  logic [1:0]   i_reqhpl;
  logic [W-1:0] i_reqaddr, i_rspdata;
  logic         d_reqready, d_reqvalid, d_reqwr, d_rspready, d_rspvalid, d_rsprerr;
  logic [1:0]   d_reqhpl;
  logic [W-1:0] d_reqaddr, d_reqwdata, d_rspdata;
  logic [3:0]   d_reqbe;
  logic         m_reqready, m_reqvalid, m_reqwr, m_rspready, m_rspvalid, m_rsprerr;
  logic [1:0]   m_reqhpl;
  logic [W-1:0] m_reqaddr, m_reqwdata, m_rspdata;
  logic [3:0]   m_reqbe;
  logic         spurious_rsp;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arb #(.C_BUS_SZ(W), .C_ORDER_DEPTH_X(2)) dut (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en),
    .i_reqready_o(i_reqready), .i_reqvalid_i(i_reqvalid), .i_reqhpl_i(i_reqhpl),
    .i_reqaddr_i(i_reqaddr), .i_rspready_i(i_rspready), .i_rspvalid_o(i_rspvalid),
    .i_rsprerr_o(i_rsprerr), .i_rspdata_o(i_rspdata),
    .d_reqready_o(d_reqready), .d_reqvalid_i(d_reqvalid), .d_reqhpl_i(d_reqhpl),
    .d_reqaddr_i(d_reqaddr), .d_reqwr_i(d_reqwr), .d_reqbe_i(d_reqbe),
    .d_reqwdata_i(d_reqwdata), .d_rspready_i(d_rspready), .d_rspvalid_o(d_rspvalid),
    .d_rsprerr_o(d_rsprerr), .d_rspdata_o(d_rspdata),
    .m_reqready_i(m_reqready), .m_reqvalid_o(m_reqvalid), .m_reqhpl_o(m_reqhpl),
    .m_reqaddr_o(m_reqaddr), .m_reqwr_o(m_reqwr), .m_reqbe_o(m_reqbe),
    .m_reqwdata_o(m_reqwdata), .m_rspready_o(m_rspready), .m_rspvalid_i(m_rspvalid),
    .m_rsprerr_i(m_rsprerr), .m_rspdata_i(m_rspdata), .spurious_rsp_o(spurious_rsp)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] ia;
    logic         dv;
    logic         dwr;
    logic [W-1:0] da;
    logic         mrdy;
    logic         mrv;
    logic [W-1:0] mdata;
    logic         irr;
    logic         drr;
    logic         e_mval;
    logic [W-1:0] e_maddr;
    logic         e_mwr;
    logic         e_iry;
    logic         e_dry;
    logic         e_mrr;
    logic         e_irv;
    logic         e_drv;
    logic         e_spur;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl[NV];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_reqvalid = 1'b0; i_reqaddr = '0; i_rspready = 1'b0;
    d_reqvalid = 1'b0; d_reqaddr = '0; d_reqwr = 1'b0; d_rspready = 1'b0;
    m_reqready = 1'b0; m_rspvalid = 1'b0; m_rspdata = '0; m_rsprerr = 1'b0;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("reset spurious", {31'b0, spurious_rsp}, 0);
    check("reset mreqvalid", {31'b0, m_reqvalid}, 0);
    check("reset rspready", {31'b0, m_rspready}, 0);
    @(negedge clk);
    resetb = 1'b1;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    i_reqvalid = v.iv;  i_reqaddr = v.ia;
    d_reqvalid = v.dv;  d_reqwr = v.dwr; d_reqaddr = v.da;
    m_reqready = v.mrdy; m_rspvalid = v.mrv; m_rspdata = v.mdata;
    i_rspready = v.irr; d_rspready = v.drr;
    #1;
    check($sformatf("v%0d m_reqvalid", idx), {31'b0, m_reqvalid}, {31'b0, v.e_mval});
    if (v.e_mval) begin
      check($sformatf("v%0d m_reqaddr", idx), m_reqaddr, v.e_maddr);
      check($sformatf("v%0d m_reqwr", idx), {31'b0, m_reqwr}, {31'b0, v.e_mwr});
    end
    check($sformatf("v%0d i_reqready", idx), {31'b0, i_reqready}, {31'b0, v.e_iry});
    check($sformatf("v%0d d_reqready", idx), {31'b0, d_reqready}, {31'b0, v.e_dry});
    check($sformatf("v%0d m_rspready", idx), {31'b0, m_rspready}, {31'b0, v.e_mrr});
    check($sformatf("v%0d i_rspvalid", idx), {31'b0, i_rspvalid}, {31'b0, v.e_irv});
    check($sformatf("v%0d d_rspvalid", idx), {31'b0, d_rspvalid}, {31'b0, v.e_drv});
    check($sformatf("v%0d spurious", idx), {31'b0, spurious_rsp}, {31'b0, v.e_spur});
    check($sformatf("v%0d i_rspdata", idx), i_rspdata, v.mdata);
    check($sformatf("v%0d d_rspdata", idx), d_rspdata, v.mdata);
  endtask

  initial begin
    // iv ia dv dwr da mrdy | mrv mdata irr drr | mval maddr mwr iry dry mrr irv drv spur
    tbl[0]  = '{0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 'h100,  1, 1, 'h200,  1, 0, 0,            0, 0, 1, 'h100,  0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 'h104,  1, 1, 'h200,  1, 0, 0,            0, 0, 1, 'h200,  1, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 'h108,  1, 1, 'h204,  1, 0, 0,            0, 0, 1, 'h108,  0, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0,      0, 0, 0,      0, 1, 'h11111111,   1, 1, 0, 0,      0, 0, 0, 1, 1, 0, 0};
    tbl[5]  = '{0, 0,      0, 0, 0,      0, 1, 'h22222222,   1, 1, 0, 0,      0, 0, 0, 1, 0, 1, 0};
    tbl[6]  = '{0, 0,      0, 0, 0,      0, 1, 'h33333333,   1, 1, 0, 0,      0, 0, 0, 1, 1, 0, 0};
    tbl[7]  = '{0, 0,      1, 0, 'h300,  1, 0, 0,            0, 0, 1, 'h300,  0, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0,      0, 0, 0,      0, 1, 'h44444444,   1, 0, 0, 0,      0, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{0, 0,      0, 0, 0,      0, 1, 'h44444444,   1, 1, 0, 0,      0, 0, 0, 1, 0, 1, 0};
    tbl[10] = '{1, 'h3f0,  0, 0, 0,      1, 0, 0,            0, 0, 1, 'h3f0,  0, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 'h400,  0, 0, 0,      0, 0, 0,            0, 0, 1, 'h400,  0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 'h400,  1, 0, 'h500,  0, 0, 0,            0, 0, 1, 'h400,  0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 'h400,  1, 0, 'h500,  0, 0, 0,            0, 0, 1, 'h400,  0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 'h400,  1, 0, 'h500,  1, 0, 0,            0, 0, 1, 'h400,  0, 1, 0, 0, 0, 0, 0};
    tbl[15] = '{1, 'h404,  1, 0, 'h500,  1, 0, 0,            0, 0, 1, 'h500,  0, 0, 1, 0, 0, 0, 0};
    tbl[16] = '{1, 'h404,  0, 0, 0,      1, 0, 0,            0, 0, 1, 'h404,  0, 1, 0, 0, 0, 0, 0};
    tbl[17] = '{1, 'h408,  0, 0, 0,      1, 0, 0,            0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{1, 'h408,  0, 0, 0,      1, 1, 'h55555555,   1, 0, 0, 0,      0, 0, 0, 1, 1, 0, 0};
    tbl[19] = '{1, 'h408,  0, 0, 0,      1, 0, 0,            0, 0, 1, 'h408,  0, 1, 0, 0, 0, 0, 0};
    tbl[20] = '{0, 0,      0, 0, 0,      0, 1, 'h66666666,   1, 1, 0, 0,      0, 0, 0, 1, 1, 0, 0};
    tbl[21] = '{0, 0,      1, 1, 'h600,  1, 1, 'h77777777,   1, 1, 1, 'h600,  1, 0, 1, 1, 0, 1, 0};
    tbl[22] = '{0, 0,      0, 0, 0,      0, 1, 'h88888888,   1, 1, 0, 0,      0, 0, 0, 1, 1, 0, 0};
    tbl[23] = '{0, 0,      0, 0, 0,      0, 1, 'h99999999,   1, 1, 0, 0,      0, 0, 0, 1, 1, 0, 0};
    tbl[24] = '{0, 0,      0, 0, 0,      0, 1, 'haaaaaaaa,   1, 1, 0, 0,      0, 0, 0, 1, 0, 1, 0};
    tbl[25] = '{0, 0,      0, 0, 0,      0, 1, 'hbbbbbbbb,   1, 1, 0, 0,      0, 0, 0, 0, 0, 0, 0};
    tbl[26] = '{0, 0,      0, 0, 0,      0, 0, 0,            0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 1};

    clk_en     = 1'b1;
    i_reqhpl   = 2'b10;
    d_reqhpl   = 2'b01;
    d_reqbe    = 4'h3;
    d_reqwdata = 32'ha5a5a5a5;
    do_reset();

    for (int i = 0; i < NV; i++) apply_vec(i, tbl[i]);

    // Tie after reset goes to I; I payload defaults and response broadcast.
    do_reset();
    @(negedge clk);
    i_reqvalid = 1'b1; i_reqaddr = 32'h100;
    d_reqvalid = 1'b1; d_reqaddr = 32'h200; d_reqwr = 1'b1; m_reqready = 1'b1;
    #1;
    check("pay i_reqready", {31'b0, i_reqready}, 1);
    check("pay d_reqready", {31'b0, d_reqready}, 0);
    check("pay addr", m_reqaddr, 32'h100);
    check("pay wr", {31'b0, m_reqwr}, 0);
    check("pay be", {28'b0, m_reqbe}, 32'hf);
    check("pay wdata", m_reqwdata, 0);
    check("pay hpl", {30'b0, m_reqhpl}, 2);
    @(negedge clk);
    idle_inputs();
    m_rspvalid = 1'b1; m_rspdata = 32'hdeadbeef; m_rsprerr = 1'b1; i_rspready = 1'b1;
    #1;
    check("rsp i_rspvalid", {31'b0, i_rspvalid}, 1);
    check("rsp d_rspvalid", {31'b0, d_rspvalid}, 0);
    check("rsp i_rspdata", i_rspdata, 32'hdeadbeef);
    check("rsp i_rsprerr", {31'b0, i_rsprerr}, 1);
    check("rsp d_rsprerr", {31'b0, d_rsprerr}, 1);
    @(negedge clk);
    idle_inputs();
    d_reqvalid = 1'b1; d_reqaddr = 32'h200; d_reqwr = 1'b1; m_reqready = 1'b1;
    #1;
    check("dpay d_reqready", {31'b0, d_reqready}, 1);
    check("dpay wr", {31'b0, m_reqwr}, 1);
    check("dpay be", {28'b0, m_reqbe}, 32'h3);
    check("dpay wdata", m_reqwdata, 32'ha5a5a5a5);
    check("dpay hpl", {30'b0, m_reqhpl}, 1);
    @(negedge clk);
    idle_inputs();
    m_rspvalid = 1'b1; d_rspready = 1'b1;
    #1;
    check("dpay drain", {31'b0, d_rspvalid}, 1);

    // Clock enable low: outputs follow inputs but nothing is recorded.
    @(negedge clk);
    idle_inputs();
    clk_en = 1'b0;
    i_reqvalid = 1'b1; i_reqaddr = 32'h700; m_reqready = 1'b1;
    #1;
    check("cen i_reqready", {31'b0, i_reqready}, 1);
    check("cen m_reqvalid", {31'b0, m_reqvalid}, 1);
    @(negedge clk);
    idle_inputs();
    m_rspvalid = 1'b1; i_rspready = 1'b1;
    #1;
    check("cen no push rspready", {31'b0, m_rspready}, 0);
    check("cen no push i_rspvalid", {31'b0, i_rspvalid}, 0);
    @(negedge clk);
    idle_inputs();
    clk_en = 1'b1;
    #1;
    check("cen spurious held", {31'b0, spurious_rsp}, 0);

    // Reset with a request outstanding: the later response is spurious.
    @(negedge clk);
    i_reqvalid = 1'b1; i_reqaddr = 32'h800; m_reqready = 1'b1;
    #1;
    check("rmid accept", {31'b0, i_reqready}, 1);
    @(negedge clk);
    idle_inputs();
    resetb = 1'b0;
    #2;
    resetb = 1'b1;
    m_rspvalid = 1'b1; i_rspready = 1'b1;
    #1;
    check("rmid rspready", {31'b0, m_rspready}, 0);
    check("rmid i_rspvalid", {31'b0, i_rspvalid}, 0);
    check("rmid spurious pre", {31'b0, spurious_rsp}, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("rmid spurious set", {31'b0, spurious_rsp}, 1);
    repeat (3) @(negedge clk);
    #1;
    check("rmid spurious sticky", {31'b0, spurious_rsp}, 1);
    resetb = 1'b0;
    #1;
    check("rmid spurious cleared", {31'b0, spurious_rsp}, 0);
    @(negedge clk);
    resetb = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Two-to-one arbiter that shares one single-beat memory request/response port between the instruction fetch unit (I side) and the load/store unit (D side).
- Grants requests round-robin and holds each grant until the memory accepts the request.
- Records the source of every accepted request in an order FIFO, so in-order memory responses go back to the requester that issued them.
- Sits between the core's fetch/LSU stages and the external memory/cache port.

Parameters:
- C_BUS_SZ, 32, address and data width in bits; must be a multiple of 8.
- C_ORDER_DEPTH_X, 2, log2 of the order-FIFO depth (maximum outstanding requests = 2**C_ORDER_DEPTH_X).

Ports:
- clk_i  in  1  clock
- resetb_i  in  1  reset; asynchronous, active-low
- clk_en_i  in  1  clock enable; all state updates only when high
- i_reqready_o  out  1  I request accepted
- i_reqvalid_i  in  1  I request valid
- i_reqhpl_i  in  2  I HART privilege level
- i_reqaddr_i  in  C_BUS_SZ  I address
- i_rspready_i  in  1  I can take a response
- i_rspvalid_o  out  1  I response valid
- i_rsprerr_o  out  1  I response error
- i_rspdata_o  out  C_BUS_SZ  I response data
- d_reqready_o  out  1  D request accepted
- d_reqvalid_i  in  1  D request valid
- d_reqhpl_i  in  2  D privilege level
- d_reqaddr_i  in  C_BUS_SZ  D address
- d_reqwr_i  in  1  D write (1) / read (0)
- d_reqbe_i  in  C_BUS_SZ/8  D byte enables
- d_reqwdata_i  in  C_BUS_SZ  D write data
- d_rspready_i  in  1  D can take a response
- d_rspvalid_o  out  1  D response valid
- d_rsprerr_o  out  1  D response error
- d_rspdata_o  out  C_BUS_SZ  D response data
- m_reqready_i  in  1  memory accepts request
- m_reqvalid_o  out  1  memory request valid
- m_reqhpl_o  out  2  muxed privilege level
- m_reqaddr_o  out  C_BUS_SZ  muxed address
- m_reqwr_o  out  1  muxed write flag (0 for I)
- m_reqbe_o  out  C_BUS_SZ/8  muxed byte enables (all ones for I)
- m_reqwdata_o  out  C_BUS_SZ  muxed write data (0 for I)
- m_rspready_o  out  1  ready for memory response
- m_rspvalid_i  in  1  memory response valid (in request order)
- m_rsprerr_i  in  1  memory response error
- m_rspdata_i  in  C_BUS_SZ  memory response data
- spurious_rsp_o  out  1  sticky flag: response arrived with no outstanding request

Behaviour:
- State: last_grant_q (0=I, 1=D), lock_q, lock_src_q, order FIFO (1-bit entries, source id) with level counter 0..2**C_ORDER_DEPTH_X, spurious_q.
- Reset values: last_grant_q=1 (first tie grants I), lock_q=0, order FIFO empty, spurious_q=0. With no inputs asserted, every valid/ready output is 0.
- Grant selection (combinational):
  - if lock_q, grant lock_src_q;
  - else if exactly one requester is valid, grant it;
  - else if both are valid, grant ~last_grant_q;
  - else no grant.
- m_reqvalid_o = granted requester's valid & ~order_full. Request payload is muxed from the granted side.
- Granted side's reqready_o = m_reqready_i & ~order_full. Non-granted side's reqready_o = 0. Latency is zero: a request can be accepted in the cycle it is presented.
- Accept = m_reqvalid_o & m_reqready_i. On accept: push source id, last_grant_q <= source, lock_q <= 0.
- If m_reqvalid_o=1 and not accepted: lock_q <= 1, lock_src_q <= source. The grant cannot move to the other side while a request is pending.
- Order full: m_reqvalid_o=0 and both reqready_o=0. Lock is not set by a full FIFO. A push is refused when full even if a pop happens in the same cycle.
- Response routing:
  - head = order FIFO head.
  - m_rspready_o = ~order_empty & (head ? d_rspready_i : i_rspready_i).
  - i_rspvalid_o = m_rspvalid_i & ~order_empty & head==0; d_rspvalid_o likewise with head==1.
  - rerr and data are broadcast to both sides; only the valid is steered.
  - Pop on m_rspvalid_i & m_rspready_o.
- Simultaneous accept and pop (FIFO not full): level is unchanged; the push and pop both take effect.
- Response while the order FIFO is empty: not routed, m_rspready_o=0, spurious_q <= 1 until reset.
- Level counter never wraps: push only when not full, pop only when not empty.
- clk_en_i=0: all registers hold; combinational outputs still follow their inputs.
- Reset mid-operation clears outstanding tracking; responses that arrive afterwards raise spurious_rsp_o.

Test Plan:
- Only I valid, addr 0x100, m_reqready_i=1 -> m_reqaddr_o=0x100, m_reqwr_o=0, m_reqbe_o=0xF, i_reqready_o=1 same cycle; response data 0xDEADBEEF -> i_rspvalid_o=1, d_rspvalid_o=0.
- Both valid every cycle, m_reqready_i=1 -> grants alternate I,D,I,D starting with I after reset; responses route to I,D,I,D in order.
- I valid with m_reqready_i=0 for 3 cycles while D raises valid in cycle 2 -> grant stays I (lock) until accept; D is granted the next cycle.
- 4 accepted requests (depth 4), no responses -> 5th request gets reqready=0 and m_reqvalid_o=0; one response pops an entry -> 5th accepted the following cycle.
- Head=D with d_rspready_i=0 -> m_rspready_o=0 and D response held; i_rspvalid_o stays 0 despite i_rspready_i=1.
- m_rspvalid_i=1 after reset with no requests -> spurious_rsp_o=1, which stays set until resetb_i goes low.
